// File: rtl/uart_prog_loader.sv
// uart_prog_loader
// Receives a UART byte stream, packs bytes little-endian into words and
// writes them to consecutive instruction-memory addresses. Loading ends
// after END_MARKERS consecutive all-ones words. Framing/parity errors and
// writes beyond the last address are reported through sticky flags.
//
// Ports
//   clk         system clock, rising edge
//   resetn      asynchronous active-low reset
//   uart_rxd    UART receive line, idle high
//   load_en     loader enable; low aborts the frame and the partial word
//   byte_valid  one-cycle pulse per accepted byte
//   byte_data   last accepted byte
//   mem_we      one-cycle memory write strobe
//   mem_addr    word address of the write
//   mem_wdata   assembled word
//   write_done  sticky, end-of-program marker sequence seen
//   rx_err      sticky, framing or parity error seen
//   overflow    sticky, complete word arrived after memory was full
module uart_prog_loader #(
  parameter int CLK_HZ      = 50000000,
  parameter int BIT_RATE    = 9600,
  parameter int WORD_BYTES  = 4,
  parameter int ADDR_W      = 10,
  parameter int PARITY      = 0,
  parameter int END_MARKERS = 2
) (
  input  logic                    clk,
  input  logic                    resetn,
  input  logic                    uart_rxd,
  input  logic                    load_en,
  output logic                    byte_valid,
  output logic [7:0]              byte_data,
  output logic                    mem_we,
  output logic [ADDR_W-1:0]       mem_addr,
  output logic [8*WORD_BYTES-1:0] mem_wdata,
  output logic                    write_done,
  output logic                    rx_err,
  output logic                    overflow
);

  localparam int CPB   = CLK_HZ / BIT_RATE;
  localparam int DW    = 8 * WORD_BYTES;
  localparam int CNT_W = $clog2(CPB + 1);
  localparam int BC_W  = (WORD_BYTES > 1) ? $clog2(WORD_BYTES) : 1;
  localparam int MC_W  = $clog2(END_MARKERS + 1);

  localparam logic [CNT_W-1:0]  HALF_CNT  = CNT_W'(CPB / 2);
  localparam logic [CNT_W-1:0]  LAST_CNT  = CNT_W'(CPB - 1);
  localparam logic [BC_W-1:0]   LAST_BYTE = BC_W'(WORD_BYTES - 1);
  localparam logic [MC_W-1:0]   MARK_DONE = MC_W'(END_MARKERS);
  localparam logic [ADDR_W-1:0] ADDR_MAX  = '1;

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_PAR, S_STOP, S_WAIT_HI
  } state_t;

  // Parity check over data plus received parity bit.
  function automatic logic parity_ok(input logic [7:0] d, input logic p);
    if (PARITY == 1)      return ~^{d, p};
    else if (PARITY == 2) return ^{d, p};
    else                  return 1'b1;
  endfunction

  logic             r_sync1, r_sync2;
  logic             w_rxs;
  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [2:0]       r_bit;
  logic [7:0]       r_shift;
  logic             r_par;
  logic             r_byte_valid;
  logic [7:0]       r_byte_data;
  logic             r_rx_err;

  logic [DW-1:0]     r_word;
  logic [BC_W-1:0]   r_bcnt;
  logic [ADDR_W-1:0] r_addr;
  logic [MC_W-1:0]   r_mcnt;
  logic [MC_W-1:0]   r_pend_mcnt;
  logic              r_full;
  logic              r_mem_we;
  logic [DW-1:0]     r_mem_wdata;
  logic              r_write_done;
  logic              r_overflow;

  logic [DW-1:0]     w_word;
  logic              w_last;
  logic [MC_W-1:0]   w_mark_next;

  // Synchroniser resets to the idle level so reset release never looks like a start bit.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
    end else begin
      r_sync1 <= uart_rxd;
      r_sync2 <= r_sync1;
    end
  end

  assign w_rxs = r_sync2;

  // Receiver: start bit checked at half-bit, later bits sampled one full bit apart.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state      <= S_IDLE;
      r_cnt        <= '0;
      r_bit        <= '0;
      r_shift      <= '0;
      r_par        <= 1'b0;
      r_byte_valid <= 1'b0;
      r_byte_data  <= '0;
      r_rx_err     <= 1'b0;
    end else begin
      r_byte_valid <= 1'b0;
      if (!load_en) begin
        r_state <= S_IDLE;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (!w_rxs) begin
              r_state <= S_START;
              r_cnt   <= '0;
            end
          end
          S_START: begin
            if (r_cnt == HALF_CNT) begin
              r_cnt <= '0;
              r_bit <= '0;
              r_state <= w_rxs ? S_IDLE : S_DATA;
            end else begin
              r_cnt <= r_cnt + CNT_W'(1);
            end
          end
          S_DATA: begin
            if (r_cnt == LAST_CNT) begin
              r_cnt   <= '0;
              r_shift <= {w_rxs, r_shift[7:1]};
              r_bit   <= r_bit + 3'd1;
              if (r_bit == 3'd7) r_state <= (PARITY != 0) ? S_PAR : S_STOP;
            end else begin
              r_cnt <= r_cnt + CNT_W'(1);
            end
          end
          S_PAR: begin
            if (r_cnt == LAST_CNT) begin
              r_cnt   <= '0;
              r_par   <= w_rxs;
              r_state <= S_STOP;
            end else begin
              r_cnt <= r_cnt + CNT_W'(1);
            end
          end
          S_STOP: begin
            if (r_cnt == LAST_CNT) begin
              r_cnt <= '0;
              if (w_rxs && parity_ok(r_shift, r_par)) begin
                r_byte_valid <= 1'b1;
                r_byte_data  <= r_shift;
                r_state      <= S_IDLE;
              end else begin
                r_rx_err <= 1'b1;
                // A low stop bit may be a break; wait for the line to return high.
                r_state  <= w_rxs ? S_IDLE : S_WAIT_HI;
              end
            end else begin
              r_cnt <= r_cnt + CNT_W'(1);
            end
          end
          S_WAIT_HI: begin
            if (w_rxs) r_state <= S_IDLE;
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

  // Word as it will look with the current byte inserted at its lane.
  always_comb begin
    w_word = r_word;
    w_word[8*int'(r_bcnt) +: 8] = r_byte_data;
    w_last = (r_bcnt == LAST_BYTE);
    w_mark_next = (&w_word) ? (r_mcnt + MC_W'(1)) : '0;
  end

  // Assembly/write. The write decision (and write_done) is registered with
  // mem_we; the address and marker count advance during the mem_we cycle.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_word       <= '0;
      r_bcnt       <= '0;
      r_addr       <= '0;
      r_mcnt       <= '0;
      r_pend_mcnt  <= '0;
      r_full       <= 1'b0;
      r_mem_we     <= 1'b0;
      r_mem_wdata  <= '0;
      r_write_done <= 1'b0;
      r_overflow   <= 1'b0;
    end else begin
      r_mem_we <= 1'b0;
      if (r_mem_we) begin
        if (r_addr == ADDR_MAX) r_full <= 1'b1;
        else                    r_addr <= r_addr + ADDR_W'(1);
        r_mcnt <= r_pend_mcnt;
      end
      if (!load_en) begin
        r_word <= '0;
        r_bcnt <= '0;
      end else if (r_byte_valid && !r_write_done) begin
        if (w_last) begin
          r_word <= '0;
          r_bcnt <= '0;
          if (r_full) begin
            r_overflow <= 1'b1;
          end else begin
            r_mem_we    <= 1'b1;
            r_mem_wdata <= w_word;
            r_pend_mcnt <= w_mark_next;
            if (w_mark_next == MARK_DONE) r_write_done <= 1'b1;
          end
        end else begin
          r_word <= w_word;
          r_bcnt <= r_bcnt + BC_W'(1);
        end
      end
    end
  end

  assign byte_valid = r_byte_valid;
  assign byte_data  = r_byte_data;
  assign mem_we     = r_mem_we;
  assign mem_addr   = r_addr;
  assign mem_wdata  = r_mem_wdata;
  assign write_done = r_write_done;
  assign rx_err     = r_rx_err;
  assign overflow   = r_overflow;

endmodule

// File: tb/tb_uart_prog_loader.sv
// Directed bench for uart_prog_loader with three instances:
//   u0: 8N1, 32-bit words, END_MARKERS=2
//   u1: even parity
//   u2: ADDR_W=2, END_MARKERS=1
// All use CPB=10 to keep frames short.
module tb_uart_prog_loader;

  localparam int CPB = 10;

  logic clk, resetn, load_en;
  logic rxd0, rxd1, rxd2;

  logic bv0, we0, done0, err0, ovf0;
  logic [7:0] bd0;
  logic [9:0] addr0;
  logic [31:0] wd0;

  logic bv1, we1, done1, err1, ovf1;
  logic [7:0] bd1;
  logic [9:0] addr1;
  logic [31:0] wd1;

  logic bv2, we2, done2, err2, ovf2;
  logic [7:0] bd2;
  logic [1:0] addr2;
  logic [31:0] wd2;

  int ntests = 0;
  int nfail  = 0;

  logic [9:0]  qa0[$];
  logic [31:0] qd0[$];
  logic        qn0[$];
  logic [1:0]  qa2[$];
  logic [31:0] qd2[$];
  int nbv0 = 0;
  int nbv1 = 0;

  uart_prog_loader #(.CLK_HZ(100), .BIT_RATE(10)) u0 (
    .clk(clk), .resetn(resetn), .uart_rxd(rxd0), .load_en(load_en),
    .byte_valid(bv0), .byte_data(bd0), .mem_we(we0), .mem_addr(addr0),
    .mem_wdata(wd0), .write_done(done0), .rx_err(err0), .overflow(ovf0));

  uart_prog_loader #(.CLK_HZ(100), .BIT_RATE(10), .PARITY(1)) u1 (
    .clk(clk), .resetn(resetn), .uart_rxd(rxd1), .load_en(load_en),
    .byte_valid(bv1), .byte_data(bd1), .mem_we(we1), .mem_addr(addr1),
    .mem_wdata(wd1), .write_done(done1), .rx_err(err1), .overflow(ovf1));

  uart_prog_loader #(.CLK_HZ(100), .BIT_RATE(10), .ADDR_W(2), .END_MARKERS(1)) u2 (
    .clk(clk), .resetn(resetn), .uart_rxd(rxd2), .load_en(load_en),
    .byte_valid(bv2), .byte_data(bd2), .mem_we(we2), .mem_addr(addr2),
    .mem_wdata(wd2), .write_done(done2), .rx_err(err2), .overflow(ovf2));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Write/byte monitors, sampled on the falling edge.
  always @(negedge clk) begin
    if (we0) begin
      qa0.push_back(addr0);
      qd0.push_back(wd0);
      qn0.push_back(done0);
    end
    if (bv0) nbv0++;
    if (bv1) nbv1++;
    if (we2) begin
      qa2.push_back(addr2);
      qd2.push_back(wd2);
    end
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: time limit reached, obs=running exp=finished");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    ntests++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic bitt(input int w, input logic v);
    case (w)
      0:       rxd0 = v;
      1:       rxd1 = v;
      default: rxd2 = v;
    endcase
    repeat (CPB) @(negedge clk);
  endtask

  task automatic send_byte(input int w, input logic [7:0] b, input logic par_en,
                           input logic par, input logic stop);
    bitt(w, 1'b0);
    for (int i = 0; i < 8; i++) bitt(w, b[i]);
    if (par_en) bitt(w, par);
    bitt(w, stop);
  endtask

  task automatic send_word(input int w, input logic [31:0] x);
    for (int i = 0; i < 4; i++) send_byte(w, x[8*i +: 8], 1'b0, 1'b0, 1'b1);
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    idle(3);
    resetn = 1'b1;
    idle(3);
  endtask

  logic [31:0] t2w [5] = '{32'h12345678, 32'hFFFFFFFF, 32'h00000013, 32'hFFFFFFFF, 32'hFFFFFFFF};
  logic [31:0] t5w [5] = '{32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444, 32'h55555555};

  initial begin
    int base;
    int b0;
    int b1;
    resetn  = 1'b0;
    load_en = 1'b1;
    rxd0 = 1'b1;
    rxd1 = 1'b1;
    rxd2 = 1'b1;
    idle(4);

    // Reset state
    chk("rst_byte_valid", bv0, 0);
    chk("rst_byte_data",  bd0, 0);
    chk("rst_mem_we",     we0, 0);
    chk("rst_mem_addr",   addr0, 0);
    chk("rst_mem_wdata",  wd0, 0);
    chk("rst_write_done", done0, 0);
    chk("rst_rx_err",     err0, 0);
    chk("rst_overflow",   ovf0, 0);
    resetn = 1'b1;
    idle(5);

    // Two program words
    send_word(0, 32'h00812E23);
    send_word(0, 32'hFE010113);
    idle(3*CPB);
    chk("t1_nwrites", qa0.size(), 2);
    chk("t1_addr0", qa0[0], 0);
    chk("t1_data0", qd0[0], 32'h00812E23);
    chk("t1_addr1", qa0[1], 1);
    chk("t1_data1", qd0[1], 32'hFE010113);
    chk("t1_done", done0, 0);
    chk("t1_addr_after", addr0, 2);
    chk("t1_nbytes", nbv0, 8);
    chk("t1_last_byte", bd0, 8'hFE);

    // End-of-program markers
    do_reset();
    base = qa0.size();
    b0 = nbv0;
    for (int i = 0; i < 5; i++) send_word(0, t2w[i]);
    idle(3*CPB);
    chk("t2_nwrites", qa0.size() - base, 5);
    for (int i = 0; i < 5; i++) begin
      chk("t2_addr", qa0[base+i], i);
      chk("t2_data", qd0[base+i], t2w[i]);
    end
    chk("t2_done_at_w3", qn0[base+3], 0);
    chk("t2_done_at_w4", qn0[base+4], 1);
    chk("t2_done", done0, 1);
    send_word(0, 32'hDEADBEEF);
    idle(3*CPB);
    chk("t2_bytes_after_done", nbv0 - b0, 24);
    chk("t2_no_write_after_done", qa0.size() - base, 5);
    chk("t2_byte_data", bd0, 8'hDE);

    // Framing error with break
    do_reset();
    base = qa0.size();
    b0 = nbv0;
    send_byte(0, 8'h11, 1'b0, 1'b0, 1'b1);
    send_byte(0, 8'h22, 1'b0, 1'b0, 1'b1);
    send_byte(0, 8'h33, 1'b0, 1'b0, 1'b0);
    bitt(0, 1'b0);
    bitt(0, 1'b0);
    bitt(0, 1'b0);
    rxd0 = 1'b1;
    idle(2*CPB);
    chk("t3_rx_err", err0, 1);
    chk("t3_bytes_bad_dropped", nbv0 - b0, 2);
    chk("t3_no_write", qa0.size() - base, 0);
    send_byte(0, 8'h44, 1'b0, 1'b0, 1'b1);
    send_byte(0, 8'h55, 1'b0, 1'b0, 1'b1);
    send_byte(0, 8'h66, 1'b0, 1'b0, 1'b1);
    send_byte(0, 8'h77, 1'b0, 1'b0, 1'b1);
    send_byte(0, 8'h88, 1'b0, 1'b0, 1'b1);
    send_byte(0, 8'h99, 1'b0, 1'b0, 1'b1);
    idle(3*CPB);
    chk("t3_nwrites", qa0.size() - base, 2);
    chk("t3_addr0", qa0[base], 0);
    chk("t3_data0", qd0[base], 32'h55442211);
    chk("t3_addr1", qa0[base+1], 1);
    chk("t3_data1", qd0[base+1], 32'h99887766);
    chk("t3_nbytes", nbv0 - b0, 8);

    // Even parity: 0xA5 has four ones, so the correct parity bit is 0
    b1 = nbv1;
    chk("t4_err_before", err1, 0);
    send_byte(1, 8'hA5, 1'b1, 1'b1, 1'b1);
    idle(2*CPB);
    chk("t4_err_badpar", err1, 1);
    chk("t4_bad_dropped", nbv1 - b1, 0);
    send_byte(1, 8'hA5, 1'b1, 1'b0, 1'b1);
    idle(2*CPB);
    chk("t4_good_accepted", nbv1 - b1, 1);
    chk("t4_byte_data", bd1, 8'hA5);

    // Overflow with a 4-word memory
    for (int i = 0; i < 4; i++) send_word(2, t5w[i]);
    idle(3*CPB);
    chk("t5_nwrites", qa2.size(), 4);
    for (int i = 0; i < 4; i++) begin
      chk("t5_addr", qa2[i], i);
      chk("t5_data", qd2[i], t5w[i]);
    end
    chk("t5_ovf_before", ovf2, 0);
    send_word(2, t5w[4]);
    idle(3*CPB);
    chk("t5_no_5th_write", qa2.size(), 4);
    chk("t5_overflow", ovf2, 1);
    chk("t5_done", done2, 0);

    // Reset in the middle of byte 3 (u0 holds addr=2, rx_err=1, data from t3)
    base = qa0.size();
    send_byte(0, 8'h0D, 1'b0, 1'b0, 1'b1);
    send_byte(0, 8'hF0, 1'b0, 1'b0, 1'b1);
    send_byte(0, 8'hFE, 1'b0, 1'b0, 1'b1);
    bitt(0, 1'b0);
    bitt(0, 1'b0);
    bitt(0, 1'b1);
    bitt(0, 1'b0);
    resetn = 1'b0;
    #1;
    chk("t6_rst_byte_data", bd0, 0);
    chk("t6_rst_mem_addr",  addr0, 0);
    chk("t6_rst_mem_wdata", wd0, 0);
    chk("t6_rst_rx_err",    err0, 0);
    chk("t6_rst_mem_we",    we0, 0);
    chk("t6_rst_done",      done0, 0);
    rxd0 = 1'b1;
    idle(3);
    resetn = 1'b1;
    idle(3*CPB);
    send_word(0, 32'h11223344);
    idle(3*CPB);
    chk("t6_nwrites", qa0.size() - base, 1);
    chk("t6_addr", qa0[base], 0);
    chk("t6_data", qd0[base], 32'h11223344);

    // load_en drop mid-word
    send_byte(0, 8'hAA, 1'b0, 1'b0, 1'b1);
    send_byte(0, 8'hBB, 1'b0, 1'b0, 1'b1);
    idle(CPB);
    load_en = 1'b0;
    idle(5);
    chk("t6_addr_kept", addr0, 1);
    load_en = 1'b1;
    idle(CPB);
    send_word(0, 32'h55667788);
    idle(3*CPB);
    chk("t6_nwrites2", qa0.size() - base, 2);
    chk("t6_addr2", qa0[base+1], 1);
    chk("t6_data2", qd0[base+1], 32'h55667788);
    chk("t6_addr_after", addr0, 2);

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule

// File: doc/uart_prog_loader.md
# uart_prog_loader

Parametrised UART program loader: receives a serial byte stream on the UART RX pin, assembles little-endian words, and writes them sequentially into instruction memory. It is the next-generation replacement for the fixed 8N1/32-bit receive-and-store path in the `wrapper` top level. It adds configurable word width, depth, baud, parity and end-of-program detection. It also adds error and overflow reporting. It sits between the board RX pin and the instruction-memory write port, and signals `write_done` to release the core from reset.

## Interface
- `CLK_HZ`, 50000000, system clock frequency.
- `BIT_RATE`, 9600, UART baud; `CPB = CLK_HZ/BIT_RATE` (integer divide) clocks per bit.
- `WORD_BYTES`, 4, bytes per memory word (1..8); `DW = 8*WORD_BYTES`.
- `ADDR_W`, 10, word-address width; depth `2**ADDR_W`.
- `PARITY`, 0, parity mode: 0 none, 1 even, 2 odd.
- `END_MARKERS`, 2, consecutive all-ones words that terminate loading (>=1).
- `clk  in  1`  system clock, all logic on rising edge.
- `resetn  in  1`  asynchronous active-low reset.
- `uart_rxd  in  1`  UART receive pin, idle high.
- `load_en  in  1`  loader enable.
- `byte_valid  out  1`  one-cycle pulse per accepted byte.
- `byte_data  out  8`  last accepted byte.
- `mem_we  out  1`  one-cycle memory write strobe.
- `mem_addr  out  ADDR_W`  word address.
- `mem_wdata  out  DW`  assembled word.
- `write_done  out  1`  sticky, end-of-program reached.
- `rx_err  out  1`  sticky, framing or parity error seen.
- `overflow  out  1`  sticky, word received after memory full.

## Operation
- Reset values: all outputs 0; the internal address counter and marker count are 0; the synchroniser flops are set to 1.
- The RX path uses a 2-flop synchroniser on `uart_rxd`. All sampling uses the synchronised value `rxs`.
- RX state machine: IDLE, START, DATA, PAR, STOP, WAIT_HI.
  - IDLE -> START when `rxs`=0 and `load_en`=1, and the bit counter is cleared.
  - START: sample at count `CPB/2`. If 0, go to DATA and restart the counter. If 1, it is a glitch; return to IDLE.
  - DATA: sample every `CPB` clocks, LSB first, 8 bits. Then go to PAR if `PARITY`!=0, else to STOP.
  - PAR: sample one bit and check even/odd parity over the data plus the parity bit.
  - STOP: sample after `CPB` clocks.
    - Stop=1 and parity OK: accept the byte and go to IDLE.
    - Stop=0 or parity bad: set `rx_err` and discard the byte. Go to WAIT_HI if stop=0, else IDLE.
  - WAIT_HI: remain until `rxs`=1, then go to IDLE. This is how a break condition is handled.
- Assembly: byte k of a word is placed in `mem_wdata[8k+7:8k]`. A byte counter runs 0..WORD_BYTES-1 and wraps.
- On the final byte of a word:
  - Write the word (`mem_we` pulse) at the current address.
  - Increment the address.
  - If the word is all ones, increment the marker count; otherwise clear the marker count to 0.
  - When the marker count reaches `END_MARKERS`, set `write_done`. Marker words are written to memory.
- Full: once address `2**ADDR_W-1` has been written, the address is held at that value and the block is marked full. A further complete word is not written and sets `overflow`.
- After `write_done`, all further bytes are received (`byte_valid` still pulses) but are not assembled or written.
- `load_en` low:
  - The RX machine is forced to IDLE, aborting any byte in flight.
  - The partial word and byte counter are cleared.
  - The address, marker count and sticky flags are retained.
- `resetn` low at any point returns every register to its reset value immediately, including mid-byte and mid-word.

## Timing
- `byte_valid` and `byte_data` are registered, valid in the cycle after the stop-bit sample. `byte_data` holds its value until the next accepted byte.
- `mem_we`, `mem_addr` and `mem_wdata` are valid in the cycle after the `byte_valid` of the final byte. `mem_addr` and `mem_wdata` are stable while `mem_we`=1.
- The address increment and marker-count update are visible in the cycle after `mem_we`.
- `write_done` rises in the same cycle as the `mem_we` of the terminating marker word.
- `rx_err` rises in the cycle after the bad STOP or parity sample.
- Inter-byte gap: any length of at least 0 idle bits is accepted. Back-to-back frames must be received.
- Word throughput is bounded only by the UART; there is no backpressure.

## Test plan
- Defaults, 8N1 at CPB=5208. Send words 0x00812E23 then 0xFE010113 as 8 bytes, LSB first. Required: `mem_we` at addr 0 with data 0x00812E23, then at addr 1 with 0xFE010113; `write_done`=0.
- Send 0x12345678, 0xFFFFFFFF, 0x00000013, 0xFFFFFFFF, 0xFFFFFFFF. Required: five writes (addr 0..4); `write_done` rises with the addr-4 write; a following byte gives `byte_valid` but no `mem_we`.
- Stop bit forced to 0 on byte 2 of a word. Required: `rx_err`=1, no `byte_valid` for that byte, the line is held low for 3 bit times with no spurious byte; the following 4 good bytes produce a write at the correct address.
- `PARITY`=1: byte 0xA5 sent with a wrong parity bit. Required: `rx_err`=1 and the byte is discarded. The same byte with correct parity is accepted, `byte_data`=0xA5.
- `ADDR_W`=2, `END_MARKERS`=1: send 5 non-marker words. Required: writes to addr 0..3, the 5th word gives no `mem_we`, `overflow`=1.
- Assert `resetn`=0 mid-way through byte 3 of a word, then release. Required: all outputs 0, the next word written at addr 0 with the correct data. Drop `load_en` mid-word: the partial word is discarded, `mem_addr` is unchanged.
